ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  CPU-side memory arbiter: merges the fetch port (imem) and the load/store port (dmem)
//  onto the single cpu_ram_if cpu modport. Sits directly upstream of the RAM.
//  Serialises accesses, counts fixed RAM read latency, issues one done pulse per request.
// PARAMETERS
//  RAM_LATENCY  1  cycles ram_ren held before ram_load is sampled (>=1)
// PORTS
//  clk          in   1   clock, shared with RAM (ram_clk)
//  rst          in   1   synchronous, active-high reset
//  imem_req     in   1   fetch read request; held stable until imem_done
//  imem_addr    in   32  fetch byte address (word_t)
//  imem_rdata   out  32  fetched word; valid in imem_done cycle
//  imem_done    out  1   one-cycle completion pulse
//  dmem_ren     in   1   load request; held until dmem_done
//  dmem_wen     in   1   store request; held until dmem_done
//  dmem_addr    in   32  load/store byte address
//  dmem_wdata   in   32  store data, right-aligned for BYTE/HALF
//  dmem_size    in   2   mem_size_t: BYTE=0 HALF=1 WORD=2
//  dmem_rdata   out  32  full aligned word; LSU extracts/extends; valid in done cycle
//  dmem_done    out  1   one-cycle completion pulse
//  dmem_err     out  1   asserted with dmem_done when request rejected
//  ram_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  ram_store    out  32  write data
//  ram_ren      out  1   RAM read enable
//  ram_wen      out  1   RAM write enable
//  ram_load     in   32  RAM read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=IMEM. All outputs registered.
//  FSM: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, DONE.
//  IDLE: dmem pending and imem pending -> grant side opposite last_grant; else sole requester.
//   Grant updates last_grant. Nothing pending -> stay IDLE.
//  Error check at grant (dmem only): ren&wen both set; size=3; HALF with addr[0]=1;
//   WORD with addr[1:0]!=0 -> DONE with dmem_err=1, no RAM access.
//  READ: ram_ren=1, ram_addr held for RAM_LATENCY cycles; ram_load captured on last one -> DONE.
//  WRITE (WORD store): ram_wen=1 one cycle, ram_store=dmem_wdata -> DONE.
//  DONE: one cycle, done (+err) for granted side, rdata register held until next done -> IDLE.
//  Timing (L=RAM_LATENCY, request seen in cycle 0): ram_ren cycles 1..L, done cycle L+1;
//   word store: ram_wen cycle 1, done cycle 2; error: done cycle 1.
//  No re-accept in DONE; requester changes request on edge ending done cycle.
//  Request dropped before done: illegal; arbiter completes access, done still pulsed.
//  rst mid-access: next edge -> IDLE, ren/wen/done deasserted, no done for aborted access.
// CONFIGURATION
//  SUBWORD_RMW_EN defined: BYTE/HALF store -> RMW_READ (as READ) then RMW_WRITE: one
//   ram_wen cycle with captured word, target lanes replaced per addr[1:0] -> DONE.
//   Done at cycle L+2. Misaligned HALF still errors.
//  Undefined: BYTE/HALF store -> dmem_err. Sub-word loads unaffected. RMW states absent.
// STRUCTURE
//  rv32ima_pkg gains: mem_size_t enum, arb_state_t enum, grant_t {IMEM,DMEM}.
//  Sub-module ram_store_merge (combinational: old word, wdata, size, addr[1:0] -> merged),
//   instantiated only under SUBWORD_RMW_EN.
// TESTING
//  imem_req, addr=0x100, RAM[0x100]=0xDEADBEEF, L=1 -> ram_ren cycle 1, imem_done cycle 2, data OK.
//  Both pending after reset (last=IMEM): dmem load 0x200 then imem 0x104; IDLE gaps seen.
//  dmem WORD store 0x12345678 @0x300 -> ram_wen one cycle @0x300, done cycle 2, read-back OK.
//  RMW_EN: RAM[0x40]=0x11223344, BYTE store 0xAA @0x41 -> RAM 0x1122AA44, done cycle 3.
//  HALF store @0x43 -> done+err cycle 1, ram_ren/ram_wen never high; no-RMW BYTE store -> err.
//  L=3, rst in cycle 2 of read -> ren low next cycle, no done, next fetch serviced normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the CPU-side RAM arbiter: access sizes, arbiter states,
// grant sides and the dmem request legality check.
// Build option: SUBWORD_RMW_EN adds the read-modify-write states used for
// BYTE/HALF stores.
package ram_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_DONE      = 3'd3
`ifdef SUBWORD_RMW_EN
        ,
        ST_RMW_READ  = 3'd4,
        ST_RMW_WRITE = 3'd5
`endif
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } grant_t;

    // A dmem request is rejected without touching the RAM when it is ambiguous
    // (load and store together), uses the reserved size code, is misaligned
    // for its size, or is a sub-word store the build cannot merge.
    function automatic logic dmem_req_bad(input logic       ren,
                                          input logic       wen,
                                          input logic [1:0] size,
                                          input logic [1:0] addr_lo,
                                          input logic       subword_store_ok);
        logic bad;
        bad = 1'b0;
        if (ren && wen)                          bad = 1'b1;
        if (size == 2'd3)                        bad = 1'b1;
        if (size == HALF && addr_lo[0])          bad = 1'b1;
        if (size == WORD && addr_lo != 2'b00)    bad = 1'b1;
        if (wen && !ren && size != WORD && !subword_store_ok) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/ram_arbiter_store_merge.sv
// Combinational lane merge for sub-word stores: replaces the byte or halfword
// lanes selected by the low address bits in the old RAM word with the
// right-aligned store data. Only instantiated when SUBWORD_RMW_EN is defined.
module ram_arbiter_store_merge
    import ram_arbiter_pkg::*;
(
    input  word_t      old_word,
    input  word_t      wdata,
    input  logic [1:0] size,
    input  logic [1:0] byte_off,
    output word_t      merged
);

    // Select the target lanes from size and byte offset
    always_comb begin
        merged = old_word;
        case (mem_size_t'(size))
            BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            HALF: begin
                if (byte_off[1]) merged[31:16] = wdata[15:0];
                else             merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// CPU-side RAM arbiter: serialises fetch (imem) and load/store (dmem) accesses
// onto one RAM port, counts the fixed RAM read latency and returns exactly one
// done pulse per accepted request. All outputs are registered.
// Build option: SUBWORD_RMW_EN enables BYTE/HALF stores via read-modify-write;
// without it such stores complete with dmem_err.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_done,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [1:0]  dmem_size,
    output logic [31:0] dmem_rdata,
    output logic        dmem_done,
    output logic        dmem_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    output logic        ram_ren,
    output logic        ram_wen,
    input  logic [31:0] ram_load
);

    localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);
`ifdef SUBWORD_RMW_EN
    localparam logic SUBWORD_OK = 1'b1;
`else
    localparam logic SUBWORD_OK = 1'b0;
`endif

    arb_state_t       state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    grant_t           grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    word_t            imem_rdata_q, imem_rdata_d;
    word_t            dmem_rdata_q, dmem_rdata_d;
    logic             imem_done_q, imem_done_d;
    logic             dmem_done_q, dmem_done_d;
    logic             dmem_err_q, dmem_err_d;
    word_t            ram_addr_q, ram_addr_d;
    word_t            ram_store_q, ram_store_d;
    logic             ram_ren_q, ram_ren_d;
    logic             ram_wen_q, ram_wen_d;
    logic             dmem_pend;
    grant_t           pick;

`ifdef SUBWORD_RMW_EN
    word_t            wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       lo_q, lo_d;
    word_t            merged_word;

    ram_arbiter_store_merge u_merge (
        .old_word (ram_load),
        .wdata    (wdata_q),
        .size     (size_q),
        .byte_off (lo_q),
        .merged   (merged_word)
    );
`endif

    assign imem_rdata = imem_rdata_q;
    assign imem_done  = imem_done_q;
    assign dmem_rdata = dmem_rdata_q;
    assign dmem_done  = dmem_done_q;
    assign dmem_err   = dmem_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_store  = ram_store_q;
    assign ram_ren    = ram_ren_q;
    assign ram_wen    = ram_wen_q;

    // Next-state and next-output logic for the arbiter FSM
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_done_d  = 1'b0;
        dmem_done_d  = 1'b0;
        dmem_err_d   = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_store_d  = ram_store_q;
        ram_ren_d    = ram_ren_q;
        ram_wen_d    = 1'b0;
        dmem_pend    = dmem_ren | dmem_wen;
        pick         = IMEM;
`ifdef SUBWORD_RMW_EN
        wdata_d      = wdata_q;
        size_d       = size_q;
        lo_d         = lo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (imem_req || dmem_pend) begin
                    // Round-robin only matters when both sides are waiting
                    if (imem_req && dmem_pend)
                        pick = (last_grant_q == IMEM) ? DMEM : IMEM;
                    else
                        pick = imem_req ? IMEM : DMEM;
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_d        = '0;
                    if (pick == IMEM) begin
                        state_d    = ST_READ;
                        ram_ren_d  = 1'b1;
                        ram_addr_d = imem_addr & ~32'h3;
                    end else if (dmem_req_bad(dmem_ren, dmem_wen, dmem_size,
                                              dmem_addr[1:0], SUBWORD_OK)) begin
                        state_d     = ST_DONE;
                        dmem_done_d = 1'b1;
                        dmem_err_d  = 1'b1;
                    end else if (dmem_ren) begin
                        state_d    = ST_READ;
                        ram_ren_d  = 1'b1;
                        ram_addr_d = dmem_addr & ~32'h3;
                    end else if (dmem_size == WORD) begin
                        state_d     = ST_WRITE;
                        ram_wen_d   = 1'b1;
                        ram_addr_d  = dmem_addr & ~32'h3;
                        ram_store_d = dmem_wdata;
                    end
`ifdef SUBWORD_RMW_EN
                    else begin
                        state_d    = ST_RMW_READ;
                        ram_ren_d  = 1'b1;
                        ram_addr_d = dmem_addr & ~32'h3;
                        wdata_d    = dmem_wdata;
                        size_d     = dmem_size;
                        lo_d       = dmem_addr[1:0];
                    end
`endif
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_LAST) begin
                    ram_ren_d = 1'b0;
                    state_d   = ST_DONE;
                    if (grant_q == IMEM) begin
                        imem_rdata_d = ram_load;
                        imem_done_d  = 1'b1;
                    end else begin
                        dmem_rdata_d = ram_load;
                        dmem_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                state_d     = ST_DONE;
                dmem_done_d = 1'b1;
            end
`ifdef SUBWORD_RMW_EN
            ST_RMW_READ: begin
                if (cnt_q == CNT_LAST) begin
                    ram_ren_d   = 1'b0;
                    ram_wen_d   = 1'b1;
                    ram_store_d = merged_word;
                    state_d     = ST_RMW_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RMW_WRITE: begin
                state_d     = ST_DONE;
                dmem_done_d = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                ram_ren_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IMEM;
            grant_q      <= IMEM;
            cnt_q        <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_done_q  <= 1'b0;
            dmem_done_q  <= 1'b0;
            dmem_err_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_store_q  <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            imem_done_q  <= imem_done_d;
            dmem_done_q  <= dmem_done_d;
            dmem_err_q   <= dmem_err_d;
            ram_addr_q   <= ram_addr_d;
            ram_store_q  <= ram_store_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
        end
    end

`ifdef SUBWORD_RMW_EN
    // Sub-word store operands captured at grant; pure data, no reset needed
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        size_q  <= size_d;
        lo_q    <= lo_d;
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at RAM_LATENCY=1 and one at
// RAM_LATENCY=3 sharing a word-addressed RAM model whose read data is only
// valid in the last cycle of a read-enable burst.
// Build option: SUBWORD_RMW_EN selects the expected sub-word store behaviour.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        imem_req, dmem_ren, dmem_wen, imem_done, dmem_done, dmem_err;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_size;
    logic [31:0] ram_addr, ram_store, ram_load;
    logic        ram_ren, ram_wen;

    logic        imem_req3, dmem_ren3, dmem_wen3, imem_done3, dmem_done3, dmem_err3;
    logic [31:0] imem_addr3, imem_rdata3, dmem_addr3, dmem_wdata3, dmem_rdata3;
    logic [1:0]  dmem_size3;
    logic [31:0] ram_addr3, ram_store3, ram_load3;
    logic        ram_ren3, ram_wen3;

    logic [31:0] mem [0:1023];
    logic        tb_we;
    logic [31:0] tb_waddr, tb_wdata;
    logic [1:0]  ren_cnt = 2'd0, ren_cnt3 = 2'd0;

    int n_vec = 0;
    int n_err = 0;

    ram_arbiter #(.RAM_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_done(imem_done),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_size(dmem_size), .dmem_rdata(dmem_rdata), .dmem_done(dmem_done), .dmem_err(dmem_err),
        .ram_addr(ram_addr), .ram_store(ram_store), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_load(ram_load)
    );

    ram_arbiter #(.RAM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req3), .imem_addr(imem_addr3), .imem_rdata(imem_rdata3), .imem_done(imem_done3),
        .dmem_ren(dmem_ren3), .dmem_wen(dmem_wen3), .dmem_addr(dmem_addr3), .dmem_wdata(dmem_wdata3),
        .dmem_size(dmem_size3), .dmem_rdata(dmem_rdata3), .dmem_done(dmem_done3), .dmem_err(dmem_err3),
        .ram_addr(ram_addr3), .ram_store(ram_store3), .ram_ren(ram_ren3), .ram_wen(ram_wen3),
        .ram_load(ram_load3)
    );

    // RAM model: read data appears only in the final cycle of the ren burst
    assign ram_load  = (ram_ren  && ren_cnt  == 2'd0) ? mem[ram_addr[11:2]]  : 32'hBAD0BAD0;
    assign ram_load3 = (ram_ren3 && ren_cnt3 == 2'd2) ? mem[ram_addr3[11:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        ren_cnt  <= ram_ren  ? ren_cnt  + 2'd1 : 2'd0;
        ren_cnt3 <= ram_ren3 ? ren_cnt3 + 2'd1 : 2'd0;
        if (tb_we)         mem[tb_waddr[11:2]]  <= tb_wdata;
        else if (ram_wen)  mem[ram_addr[11:2]]  <= ram_store;
        else if (ram_wen3) mem[ram_addr3[11:2]] <= ram_store3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if ({imem_done, dmem_done, dmem_err, ram_ren, ram_wen} !== 5'b0) begin n_err++;
            $display("FAIL reset_ctl: got %b want 00000", {imem_done, dmem_done, dmem_err, ram_ren, ram_wen}); end
        n_vec++; if ({imem_rdata, dmem_rdata, ram_addr, ram_store} !== 128'b0) begin n_err++;
            $display("FAIL reset_data: got %h want 0", {imem_rdata, dmem_rdata, ram_addr, ram_store}); end
        n_vec++; if ({imem_done3, dmem_done3, ram_ren3, ram_wen3, imem_rdata3} !== 36'b0) begin n_err++;
            $display("FAIL reset_l3: got %h want 0", {imem_done3, dmem_done3, ram_ren3, ram_wen3, imem_rdata3}); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        poke(32'h100, 32'hDEADBEEF);
        imem_req = 1'b1; imem_addr = 32'h100;
        n_vec++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL fetch_c0_ren: got %b want 0", ram_ren); end
        tick();
        n_vec++; if (ram_ren !== 1'b1) begin n_err++; $display("FAIL fetch_c1_ren: got %b want 1", ram_ren); end
        n_vec++; if (ram_addr !== 32'h100) begin n_err++; $display("FAIL fetch_c1_addr: got %h want 00000100", ram_addr); end
        n_vec++; if (imem_done !== 1'b0) begin n_err++; $display("FAIL fetch_c1_done: got %b want 0", imem_done); end
        tick();
        n_vec++; if (imem_done !== 1'b1) begin n_err++; $display("FAIL fetch_c2_done: got %b want 1", imem_done); end
        n_vec++; if (imem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_c2_data: got %h want deadbeef", imem_rdata); end
        n_vec++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL fetch_c2_ren: got %b want 0", ram_ren); end
        imem_req = 1'b0;
        tick();
        n_vec++; if (imem_done !== 1'b0) begin n_err++; $display("FAIL fetch_c3_done: got %b want 0", imem_done); end
        n_vec++; if (imem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_c3_hold: got %h want deadbeef", imem_rdata); end
    endtask

    task automatic test_arbitration();
        poke(32'h200, 32'hCAFEF00D);
        poke(32'h104, 32'h0BADC0DE);
        rst = 1'b1; tick(); rst = 1'b0;
        imem_req = 1'b1; imem_addr = 32'h104;
        dmem_ren = 1'b1; dmem_addr = 32'h200; dmem_size = 2'd2;
        tick();
        n_vec++; if ({ram_ren, ram_addr} !== {1'b1, 32'h200}) begin n_err++;
            $display("FAIL arb_c1_dmem: got ren=%b addr=%h want ren=1 addr=00000200", ram_ren, ram_addr); end
        tick();
        n_vec++; if ({dmem_done, dmem_err, imem_done} !== 3'b100) begin n_err++;
            $display("FAIL arb_c2_done: got %b want 100", {dmem_done, dmem_err, imem_done}); end
        n_vec++; if (dmem_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL arb_c2_data: got %h want cafef00d", dmem_rdata); end
        dmem_ren = 1'b0;
        tick();
        n_vec++; if ({ram_ren, dmem_done, imem_done} !== 3'b000) begin n_err++;
            $display("FAIL arb_c3_gap: got %b want 000", {ram_ren, dmem_done, imem_done}); end
        tick();
        n_vec++; if ({ram_ren, ram_addr} !== {1'b1, 32'h104}) begin n_err++;
            $display("FAIL arb_c4_imem: got ren=%b addr=%h want ren=1 addr=00000104", ram_ren, ram_addr); end
        tick();
        n_vec++; if ({imem_done, imem_rdata} !== {1'b1, 32'h0BADC0DE}) begin n_err++;
            $display("FAIL arb_c5_imem: got done=%b data=%h want done=1 data=0badc0de", imem_done, imem_rdata); end
        imem_req = 1'b0;
        tick();
    endtask

    task automatic test_word_store();
        dmem_wen = 1'b1; dmem_addr = 32'h300; dmem_wdata = 32'h12345678; dmem_size = 2'd2;
        tick();
        n_vec++; if ({ram_wen, ram_ren, ram_addr, ram_store} !== {2'b10, 32'h300, 32'h12345678}) begin n_err++;
            $display("FAIL st_c1: got wen=%b ren=%b addr=%h store=%h want 1 0 00000300 12345678", ram_wen, ram_ren, ram_addr, ram_store); end
        tick();
        n_vec++; if ({ram_wen, dmem_done, dmem_err} !== 3'b010) begin n_err++;
            $display("FAIL st_c2: got wen/done/err=%b want 010", {ram_wen, dmem_done, dmem_err}); end
        n_vec++; if (mem[32'h300 >> 2] !== 32'h12345678) begin n_err++; $display("FAIL st_mem: got %h want 12345678", mem[32'h300 >> 2]); end
        dmem_wen = 1'b0;
        tick();
        dmem_ren = 1'b1;
        tick();
        tick();
        n_vec++; if ({dmem_done, dmem_rdata} !== {1'b1, 32'h12345678}) begin n_err++;
            $display("FAIL st_readback: got done=%b data=%h want done=1 data=12345678", dmem_done, dmem_rdata); end
        dmem_ren = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        logic [35:0] vec [4];
        // {ren, wen, size, addr}
        vec[0] = {1'b0, 1'b1, 2'd1, 32'h43};
        vec[1] = {1'b1, 1'b1, 2'd2, 32'h200};
        vec[2] = {1'b1, 1'b0, 2'd3, 32'h200};
        vec[3] = {1'b1, 1'b0, 2'd2, 32'h202};
        for (int i = 0; i < 4; i++) begin
            {dmem_ren, dmem_wen, dmem_size, dmem_addr} = vec[i];
            dmem_wdata = 32'h5555;
            tick();
            n_vec++; if ({dmem_done, dmem_err, ram_ren, ram_wen} !== 4'b1100) begin n_err++;
                $display("FAIL err_c1[%0d]: got done/err/ren/wen=%b want 1100", i, {dmem_done, dmem_err, ram_ren, ram_wen}); end
            dmem_ren = 1'b0; dmem_wen = 1'b0;
            tick();
            n_vec++; if ({dmem_done, dmem_err, ram_ren, ram_wen} !== 4'b0000) begin n_err++;
                $display("FAIL err_c2[%0d]: got done/err/ren/wen=%b want 0000", i, {dmem_done, dmem_err, ram_ren, ram_wen}); end
        end
    endtask

    task automatic test_subword();
        logic [31:0] exp_word;
        poke(32'h40, 32'h11223344);
        dmem_wen = 1'b1; dmem_addr = 32'h41; dmem_wdata = 32'hAA; dmem_size = 2'd0;
        tick();
`ifdef SUBWORD_RMW_EN
        n_vec++; if ({ram_ren, ram_wen, ram_addr, dmem_done} !== {2'b10, 32'h40, 1'b0}) begin n_err++;
            $display("FAIL rmw_c1: got ren=%b wen=%b addr=%h done=%b want 1 0 00000040 0", ram_ren, ram_wen, ram_addr, dmem_done); end
        tick();
        n_vec++; if ({ram_ren, ram_wen, ram_store} !== {2'b01, 32'h1122AA44}) begin n_err++;
            $display("FAIL rmw_c2: got ren=%b wen=%b store=%h want 0 1 1122aa44", ram_ren, ram_wen, ram_store); end
        tick();
        n_vec++; if ({dmem_done, dmem_err} !== 2'b10) begin n_err++; $display("FAIL rmw_c3_done: got %b want 10", {dmem_done, dmem_err}); end
        n_vec++; if (mem[32'h40 >> 2] !== 32'h1122AA44) begin n_err++; $display("FAIL rmw_byte_mem: got %h want 1122aa44", mem[32'h40 >> 2]); end
        dmem_wen = 1'b0;
        tick();
        dmem_wen = 1'b1; dmem_addr = 32'h42; dmem_wdata = 32'hBEEF; dmem_size = 2'd1;
        tick(); tick(); tick();
        n_vec++; if ({dmem_done, dmem_err, mem[32'h40 >> 2]} !== {2'b10, 32'hBEEFAA44}) begin n_err++;
            $display("FAIL rmw_half: got done/err=%b mem=%h want 10 beefaa44", {dmem_done, dmem_err}, mem[32'h40 >> 2]); end
        exp_word = 32'hBEEFAA44;
`else
        n_vec++; if ({dmem_done, dmem_err, ram_ren, ram_wen} !== 4'b1100) begin n_err++;
            $display("FAIL norm_byte_err: got done/err/ren/wen=%b want 1100", {dmem_done, dmem_err, ram_ren, ram_wen}); end
        dmem_wen = 1'b0;
        tick();
        n_vec++; if (mem[32'h40 >> 2] !== 32'h11223344) begin n_err++; $display("FAIL norm_byte_mem: got %h want 11223344", mem[32'h40 >> 2]); end
        exp_word = 32'h11223344;
`endif
        dmem_wen = 1'b0;
        tick();
        dmem_ren = 1'b1; dmem_addr = 32'h41; dmem_size = 2'd0;
        tick();
        n_vec++; if ({ram_ren, ram_addr} !== {1'b1, 32'h40}) begin n_err++;
            $display("FAIL ldb_c1: got ren=%b addr=%h want 1 00000040", ram_ren, ram_addr); end
        tick();
        n_vec++; if ({dmem_done, dmem_err, dmem_rdata} !== {2'b10, exp_word}) begin n_err++;
            $display("FAIL ldb_c2: got done/err=%b data=%h want 10 %h", {dmem_done, dmem_err}, dmem_rdata, exp_word); end
        dmem_ren = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        imem_req3 = 1'b1; imem_addr3 = 32'h100;
        tick();
        n_vec++; if ({ram_ren3, ram_addr3} !== {1'b1, 32'h100}) begin n_err++;
            $display("FAIL l3_c1: got ren=%b addr=%h want 1 00000100", ram_ren3, ram_addr3); end
        tick();
        rst = 1'b1;
        tick();
        n_vec++; if ({ram_ren3, imem_done3} !== 2'b00) begin n_err++;
            $display("FAIL l3_abort: got ren/done=%b want 00", {ram_ren3, imem_done3}); end
        rst = 1'b0; imem_addr3 = 32'h104;
        for (int c = 4; c <= 6; c++) begin
            tick();
            n_vec++; if ({ram_ren3, ram_addr3, imem_done3} !== {1'b1, 32'h104, 1'b0}) begin n_err++;
                $display("FAIL l3_c%0d: got ren=%b addr=%h done=%b want 1 00000104 0", c, ram_ren3, ram_addr3, imem_done3); end
        end
        tick();
        n_vec++; if ({imem_done3, ram_ren3, imem_rdata3} !== {2'b10, 32'h0BADC0DE}) begin n_err++;
            $display("FAIL l3_c7: got done=%b ren=%b data=%h want 1 0 0badc0de", imem_done3, ram_ren3, imem_rdata3); end
        imem_req3 = 1'b0;
        tick();
        n_vec++; if (imem_done3 !== 1'b0) begin n_err++; $display("FAIL l3_c8: got %b want 0", imem_done3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        imem_req = 1'b0; imem_addr = '0; dmem_ren = 1'b0; dmem_wen = 1'b0;
        dmem_addr = '0; dmem_wdata = '0; dmem_size = 2'd2;
        imem_req3 = 1'b0; imem_addr3 = '0; dmem_ren3 = 1'b0; dmem_wen3 = 1'b0;
        dmem_addr3 = '0; dmem_wdata3 = '0; dmem_size3 = 2'd2;
        test_reset();
        test_fetch();
        test_arbitration();
        test_word_store();
        test_errors();
        test_subword();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
